// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 memory-mapped slave over one word-addressed memory.
//
// Write and read paths each have their own FSM, so they never stall each
// other. Burst legality is decided once, at the address handshake. An errored
// burst is still fully handshaked, but its writes are dropped and its reads
// return zero data with SLVERR.
//
// Ports:
//   ACLK, ARESET                 clock and synchronous active-high reset
//   AW*  (ADDR/LEN/SIZE/BURST)   write address channel, AWVALID/AWREADY
//   W*   (DATA/STRB/LAST)        write data channel, WVALID/WREADY
//   B*   (RESP)                  write response channel, BVALID/BREADY
//   AR*  (ADDR/LEN/SIZE/BURST)   read address channel, ARVALID/ARREADY
//   R*   (DATA/RESP/LAST)        read data channel, RVALID/RREADY
//
// Parameters: DATA_WIDTH (8..128, power of two), ADDR_WIDTH (byte address),
// MEM_DEPTH (words).
module axi4_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);      // byte-offset bits inside a word
  localparam int WAW    = ADDR_WIDTH - OFFS;   // word-address width
  localparam int MW     = $clog2(MEM_DEPTH);   // memory index width
  localparam int EXW    = WAW + 9;             // room for word address + LEN

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Burst legality, evaluated on the address-channel fields. Word-based
  // arithmetic is used throughout: the low byte-offset bits never matter
  // except for the WRAP alignment rule.
  function automatic logic burst_error(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [7:0]            len,
                                       input logic [2:0]            size,
                                       input logic [1:0]            burst);
    logic [EXW-1:0] wa;
    logic [EXW-1:0] last_wa;
    logic [EXW-1:0] max_wa;
    logic           bad;
    wa      = EXW'(addr >> OFFS);
    last_wa = wa + EXW'(len);
    bad     = (size != 3'(OFFS)) || (burst == 2'b11);
    if (burst == 2'b10) begin
      if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) bad = 1'b1;
      if ((addr & ADDR_WIDTH'(STRB_W - 1)) != '0) bad = 1'b1;
    end
    // Highest word touched: FIXED stays put, INCR runs to start+LEN, WRAP
    // stays inside its aligned window whose top word is start|LEN.
    case (burst)
      2'b00:   max_wa = wa;
      2'b01:   max_wa = last_wa;
      default: max_wa = wa | EXW'(len);
    endcase
    if (max_wa >= EXW'(MEM_DEPTH)) bad = 1'b1;
    if ((burst == 2'b01) && ((wa >> (12 - OFFS)) != (last_wa >> (12 - OFFS))))
      bad = 1'b1;
    return bad;
  endfunction

  // Next beat word address. For WRAP, LEN+1 is a power of two, so LEN itself
  // is the in-window mask and the window base is the start with those bits
  // cleared.
  function automatic logic [WAW-1:0] next_word(input logic [WAW-1:0] wa,
                                               input logic [7:0]     len,
                                               input logic [1:0]     burst);
    logic [WAW-1:0] inc;
    logic [WAW-1:0] mask;
    inc  = wa + WAW'(1);
    mask = WAW'(len);
    case (burst)
      2'b00:   return wa;
      2'b10:   return (wa & ~mask) | (inc & mask);
      default: return inc;
    endcase
  endfunction

  // ---------------------------------------------------------------- write
  w_state_t        w_state_reg, w_state_next;
  logic            awready_reg, awready_next;
  logic            wready_reg, wready_next;
  logic            bvalid_reg, bvalid_next;
  logic [1:0]      bresp_reg, bresp_next;
  logic [WAW-1:0]  w_addr_reg;
  logic [7:0]      w_len_reg;
  logic [7:0]      w_cnt_reg;
  logic [1:0]      w_burst_reg;
  logic            w_err_reg;
  logic            w_last_err_reg;

  logic aw_hs, w_hs, b_hs, w_last_beat, w_last_bad;

  assign aw_hs       = AWVALID && awready_reg;
  assign w_hs        = WVALID && wready_reg;
  assign b_hs        = bvalid_reg && BREADY;
  assign w_last_beat = (w_cnt_reg == w_len_reg);
  assign w_last_bad  = (WLAST != w_last_beat);

  always_comb begin
    w_state_next = w_state_reg;
    bresp_next   = bresp_reg;
    case (w_state_reg)
      W_IDLE: if (aw_hs) w_state_next = W_DATA;
      W_DATA: begin
        // The burst ends on the beat count; WLAST only affects the response.
        if (w_hs && w_last_beat) begin
          w_state_next = W_RESP;
          bresp_next   = (w_err_reg || w_last_err_reg || w_last_bad)
                         ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: if (b_hs) begin
        w_state_next = W_IDLE;
        bresp_next   = RESP_OKAY;
      end
      default: w_state_next = W_IDLE;
    endcase
    // Handshake outputs are registered so they read 0 while in reset and
    // rise one edge after reset is released.
    awready_next = (w_state_next == W_IDLE);
    wready_next  = (w_state_next == W_DATA);
    bvalid_next  = (w_state_next == W_RESP);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_reg    <= W_IDLE;
      awready_reg    <= 1'b0;
      wready_reg     <= 1'b0;
      bvalid_reg     <= 1'b0;
      bresp_reg      <= RESP_OKAY;
      w_addr_reg     <= '0;
      w_len_reg      <= '0;
      w_cnt_reg      <= '0;
      w_burst_reg    <= '0;
      w_err_reg      <= 1'b0;
      w_last_err_reg <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      awready_reg <= awready_next;
      wready_reg  <= wready_next;
      bvalid_reg  <= bvalid_next;
      bresp_reg   <= bresp_next;
      if (aw_hs) begin
        w_addr_reg     <= WAW'(AWADDR >> OFFS);
        w_len_reg      <= AWLEN;
        w_cnt_reg      <= '0;
        w_burst_reg    <= AWBURST;
        w_err_reg      <= burst_error(AWADDR, AWLEN, AWSIZE, AWBURST);
        w_last_err_reg <= 1'b0;
      end
      if (w_hs) begin
        w_cnt_reg  <= w_cnt_reg + 8'd1;
        w_addr_reg <= next_word(w_addr_reg, w_len_reg, w_burst_reg);
        if (w_last_bad) w_last_err_reg <= 1'b1;
      end
    end
  end

  // Memory write port; not reset. A beat presented on the reset edge is
  // dropped with the rest of the abandoned burst.
  always_ff @(posedge ACLK) begin
    if (w_hs && !w_err_reg && !ARESET) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[w_addr_reg[MW-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  r_state_t        r_state_reg, r_state_next;
  logic            arready_reg, arready_next;
  logic            rvalid_reg, rvalid_next;
  logic            rlast_reg;
  logic [1:0]      rresp_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [WAW-1:0]  r_addr_reg;
  logic [7:0]      r_len_reg;
  logic [7:0]      r_cnt_reg;
  logic [1:0]      r_burst_reg;
  logic            r_err_reg;

  logic            ar_hs, r_hs, r_load;
  logic [WAW-1:0]  r_load_addr;
  logic [7:0]      r_load_cnt, r_load_len;
  logic            r_load_err;

  assign ar_hs = ARVALID && arready_reg;
  assign r_hs  = rvalid_reg && RREADY;

  always_comb begin
    r_state_next = r_state_reg;
    r_load       = 1'b0;
    r_load_addr  = next_word(r_addr_reg, r_len_reg, r_burst_reg);
    r_load_cnt   = r_cnt_reg + 8'd1;
    r_load_len   = r_len_reg;
    r_load_err   = r_err_reg;
    case (r_state_reg)
      R_IDLE: if (ar_hs) begin
        r_state_next = R_DATA;
        r_load       = 1'b1;
        r_load_addr  = WAW'(ARADDR >> OFFS);
        r_load_cnt   = '0;
        r_load_len   = ARLEN;
        r_load_err   = burst_error(ARADDR, ARLEN, ARSIZE, ARBURST);
      end
      R_DATA: if (r_hs) begin
        if (rlast_reg) r_state_next = R_IDLE;
        else           r_load       = 1'b1;   // fetch the following beat
      end
      default: r_state_next = R_IDLE;
    endcase
    arready_next = (r_state_next == R_IDLE);
    rvalid_next  = (r_state_next == R_DATA);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rlast_reg   <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      r_addr_reg  <= '0;
      r_len_reg   <= '0;
      r_cnt_reg   <= '0;
      r_burst_reg <= '0;
      r_err_reg   <= 1'b0;
    end else begin
      r_state_reg <= r_state_next;
      arready_reg <= arready_next;
      rvalid_reg  <= rvalid_next;
      if (r_load) begin
        r_addr_reg <= r_load_addr;
        r_cnt_reg  <= r_load_cnt;
        r_len_reg  <= r_load_len;
        r_err_reg  <= r_load_err;
        rlast_reg  <= (r_load_cnt == r_load_len);
        rresp_reg  <= r_load_err ? RESP_SLVERR : RESP_OKAY;
        if (r_state_reg == R_IDLE) r_burst_reg <= ARBURST;
      end else if (r_hs && rlast_reg) begin
        rlast_reg <= 1'b0;
        rresp_reg <= RESP_OKAY;
      end
    end
  end

  // Registered memory read port. Reading the array on the same edge a write
  // lands yields the previous contents, giving read-old-data behaviour.
  always_ff @(posedge ACLK) begin
    if (ARESET)      rdata_reg <= '0;
    else if (r_load) rdata_reg <= r_load_err ? '0 : mem[r_load_addr[MW-1:0]];
  end

  assign AWREADY = awready_reg;
  assign WREADY  = wready_reg;
  assign BVALID  = bvalid_reg;
  assign BRESP   = bresp_reg;
  assign ARREADY = arready_reg;
  assign RVALID  = rvalid_reg;
  assign RLAST   = rlast_reg;
  assign RRESP   = rresp_reg;
  assign RDATA   = rdata_reg;

endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb_axi4_mem_slave: directed self-checking bench for axi4_mem_slave
// (DATA_WIDTH=32, ADDR_WIDTH=16, MEM_DEPTH=1024). Inputs change 1 ns after a
// rising edge or on a falling edge; outputs are sampled on falling edges.
module tb_axi4_mem_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [15:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  axi4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(1024)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] wbuf [16];
  logic [31:0] ebuf [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rresp_buf [16];
  logic        rlast_buf [16];
  logic [1:0]  bresp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_of(input int k);
    case (k)
      0:       return AWREADY;
      1:       return WREADY;
      2:       return BVALID;
      3:       return ARREADY;
      default: return RVALID;
    endcase
  endfunction

  // Called on a falling edge; returns on the falling edge where the signal is 1.
  task automatic wait_hi(input int k, input string tag);
    int t = 0;
    while (ready_of(k) !== 1'b1 && t < 100) begin
      @(negedge ACLK);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: observed no handshake expected one within 100 cycles", tag);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, AWREADY, 1'b0);
    check({tag, "_wready"},  WREADY,  1'b0);
    check({tag, "_bvalid"},  BVALID,  1'b0);
    check({tag, "_arready"}, ARREADY, 1'b0);
    check({tag, "_rvalid"},  RVALID,  1'b0);
    check({tag, "_rlast"},   RLAST,   1'b0);
    check({tag, "_bresp"},   BRESP,   2'b00);
    check({tag, "_rresp"},   RRESP,   2'b00);
    check({tag, "_rdata"},   RDATA,   32'h0);
  endtask

  // Starts and ends 1 ns after a rising edge. Data comes from wbuf.
  task automatic axi_write(input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] strb,
                           input bit bad_last, input int bdelay,
                           output logic [1:0] resp);
    logic [1:0] first_resp;
    AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
    @(negedge ACLK);
    wait_hi(0, "aw");
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wbuf[i]; WSTRB = strb;
      WLAST = (i == int'(len)) && !bad_last;
      WVALID = 1'b1;
      @(negedge ACLK);
      if (i == 0) begin
        check("aw_done_awready", AWREADY, 1'b0);
        check("aw_done_wready",  WREADY,  1'b1);
      end
      wait_hi(1, "w");
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = (bdelay == 0);
    @(negedge ACLK);
    check("w_done_wready", WREADY, 1'b0);
    check("w_done_bvalid", BVALID, 1'b1);
    first_resp = BRESP;
    for (int j = 0; j < bdelay; j++) begin
      check("bp_bvalid",  BVALID,  1'b1);
      check("bp_bresp",   BRESP,   first_resp);
      check("bp_awready", AWREADY, 1'b0);
      @(negedge ACLK);
    end
    BREADY = 1'b1;
    wait_hi(2, "b");
    resp = BRESP;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK);
    check("b_done_awready", AWREADY, 1'b1);
    check("b_done_bvalid",  BVALID,  1'b0);
    @(posedge ACLK); #1;
    $display("WR addr=%h len=%0d burst=%0d strb=%h bad_last=%0d bresp=%0d",
             addr, len, burst, strb, bad_last, resp);
  endtask

  // Starts and ends 1 ns after a rising edge. Beat b with stall[b] set sees
  // RREADY low for 3 cycles while its outputs must hold.
  task automatic axi_read(input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [15:0] stall);
    logic [31:0] hold_d;
    logic        hold_l;
    ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
    @(negedge ACLK);
    wait_hi(3, "ar");
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    RREADY = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      @(negedge ACLK);
      if (b == 0) check("ar_to_rvalid", RVALID, 1'b1);
      wait_hi(4, "r");
      if (stall[b]) begin
        RREADY = 1'b0;
        hold_d = RDATA;
        hold_l = RLAST;
        repeat (3) begin
          @(negedge ACLK);
          check("rbp_rvalid", RVALID, 1'b1);
          check("rbp_rdata",  RDATA,  hold_d);
          check("rbp_rlast",  RLAST,  hold_l);
        end
        RREADY = 1'b1;
      end
      rbuf[b]      = RDATA;
      rresp_buf[b] = RRESP;
      rlast_buf[b] = RLAST;
      @(posedge ACLK);
    end
    #1;
    RREADY = 1'b0;
    @(negedge ACLK);
    check("r_done_rvalid",  RVALID,  1'b0);
    check("r_done_arready", ARREADY, 1'b1);
    @(posedge ACLK); #1;
    $display("RD addr=%h len=%0d burst=%0d beat0=%h resp0=%0d last_beat=%h",
             addr, len, burst, rbuf[0], rresp_buf[0], rbuf[len]);
  endtask

  task automatic expect_read(input string tag, input int len, input logic [1:0] resp);
    for (int i = 0; i <= len; i++) begin
      check($sformatf("%s_data%0d", tag, i), rbuf[i], ebuf[i]);
      check($sformatf("%s_resp%0d", tag, i), rresp_buf[i], resp);
      check($sformatf("%s_last%0d", tag, i), rlast_buf[i], (i == len));
    end
  endtask

  task automatic set_w(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    wbuf[0] = a; wbuf[1] = b; wbuf[2] = c; wbuf[3] = d;
  endtask

  task automatic set_e(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    ebuf[0] = a; ebuf[1] = b; ebuf[2] = c; ebuf[3] = d;
  endtask

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
    RREADY = 1'b0;

    // Reset values and release timing.
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("reset");
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("release_awready_early", AWREADY, 1'b0);
    @(posedge ACLK);
    @(negedge ACLK);
    check("release_awready", AWREADY, 1'b1);
    check("release_arready", ARREADY, 1'b1);
    @(posedge ACLK); #1;

    // INCR write and read-back.
    set_w(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    axi_write(16'h0010, 8'd3, 2'b01, 4'hF, 1'b0, 0, bresp);
    check("incr_bresp", bresp, 2'b00);
    axi_read(16'h0010, 8'd3, 2'b01, 16'h0);
    set_e(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    expect_read("incr_rd", 3, 2'b00);

    // WRAP write lands at 0x18,0x1C,0x10,0x14.
    set_w(32'd1, 32'd2, 32'd3, 32'd4);
    axi_write(16'h0018, 8'd3, 2'b10, 4'hF, 1'b0, 0, bresp);
    check("wrap_bresp", bresp, 2'b00);
    axi_read(16'h0010, 8'd3, 2'b01, 16'h0);
    set_e(32'd3, 32'd4, 32'd1, 32'd2);
    expect_read("wrap_rd", 3, 2'b00);

    // Byte strobes.
    wbuf[0] = 32'h12345678;
    axi_write(16'h0040, 8'd0, 2'b01, 4'hF, 1'b0, 0, bresp);
    wbuf[0] = 32'hFFFFFFFF;
    axi_write(16'h0040, 8'd0, 2'b01, 4'b0101, 1'b0, 0, bresp);
    check("strb_bresp", bresp, 2'b00);
    axi_read(16'h0040, 8'd0, 2'b01, 16'h0);
    ebuf[0] = 32'h12FF56FF;
    expect_read("strb_rd", 0, 2'b00);

    // Out-of-range / 4 KB crossing burst: SLVERR, no write, zero read data.
    wbuf[0] = 32'hCAFEF00D;
    axi_write(16'h0FFC, 8'd0, 2'b01, 4'hF, 1'b0, 0, bresp);
    check("top_word_bresp", bresp, 2'b00);
    set_w(32'h11111111, 32'h22222222, 32'h0, 32'h0);
    axi_write(16'h0FFC, 8'd1, 2'b01, 4'hF, 1'b0, 0, bresp);
    check("oob_bresp", bresp, 2'b10);
    axi_read(16'h0FFC, 8'd1, 2'b01, 16'h0);
    set_e(32'h0, 32'h0, 32'h0, 32'h0);
    expect_read("oob_rd", 1, 2'b10);
    axi_read(16'h0FFC, 8'd0, 2'b01, 16'h0);
    ebuf[0] = 32'hCAFEF00D;
    expect_read("top_word_rd", 0, 2'b00);

    // Read backpressure on beats 2 and 3; B backpressure for 5 cycles.
    axi_read(16'h0010, 8'd3, 2'b01, 16'b0110);
    set_e(32'd3, 32'd4, 32'd1, 32'd2);
    expect_read("rbp_rd", 3, 2'b00);
    wbuf[0] = 32'h5A5A5A5A;
    axi_write(16'h0080, 8'd0, 2'b01, 4'hF, 1'b0, 5, bresp);
    check("bbp_bresp", bresp, 2'b00);

    // WLAST missing on the final beat: data still written, SLVERR.
    set_w(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    axi_write(16'h0100, 8'd3, 2'b01, 4'hF, 1'b1, 0, bresp);
    check("wlast_bresp", bresp, 2'b10);
    axi_read(16'h0100, 8'd3, 2'b01, 16'h0);
    set_e(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    expect_read("wlast_rd", 3, 2'b00);

    // Reset in the middle of a write burst.
    set_w(32'hEE000000, 32'hEE000001, 32'hEE000002, 32'hEE000003);
    axi_write(16'h0200, 8'd3, 2'b01, 4'hF, 1'b0, 0, bresp);
    AWADDR = 16'h0200; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    @(negedge ACLK);
    wait_hi(0, "rst_aw");
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WDATA = 32'hC0 + 32'(i); WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
      @(negedge ACLK);
      wait_hi(1, "rst_w");
      @(posedge ACLK); #1;
    end
    WDATA = 32'hC2;
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("midrst");
    WVALID = 1'b0;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("midrst_awready_early", AWREADY, 1'b0);
    @(posedge ACLK);
    @(negedge ACLK);
    check("midrst_awready", AWREADY, 1'b1);
    $display("RST mid-burst after 2 of 4 beats at addr=0200");
    @(posedge ACLK); #1;
    axi_read(16'h0200, 8'd3, 2'b01, 16'h0);
    set_e(32'hC0, 32'hC1, 32'hEE000002, 32'hEE000003);
    expect_read("midrst_rd", 3, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
